noc_flit_injector: RTL and testbench

- Transmitter for one router input port. It takes packets from a local word-stream source and emits 35-bit flits on the router's IDATA/IVALID/IVCH input.
- Flow control uses per-VC credits returned on the router's OACK, with per-VC ready (ORDY) and lock (OLCK) status.
- Sits in the network interface between a local core and router port 4 (local) or any mesh port.

---
 rtl/noc_flit_injector.sv | 221 ++++++++++++++++++++++
 tb/tb_noc_flit_injector.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_flit_injector.sv
// Network-interface flit transmitter: packs local word-stream packets into
// head/body/tail flits for one router input port under per-VC credit flow control.
module noc_flit_injector #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = 4
) (
    input  logic        clk,
    input  logic        RST_,
    input  logic [1:0]  MY_XPOS,
    input  logic [1:0]  MY_YPOS,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_data,
    input  logic        s_last,
    input  logic        s_vc,
    input  logic [1:0]  s_dst_x,
    input  logic [1:0]  s_dst_y,
    output logic [34:0] ODATA,
    output logic        OVALID,
    output logic        OVCH,
    input  logic [1:0]  IACK,
    input  logic [1:0]  IRDY,
    input  logic [1:0]  ILCK,
    output logic        cred_err,
    output logic [15:0] pkt_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HEAD = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    localparam logic [CW-1:0] CRED_MAX  = CW'(DEPTH);
    localparam logic [CW-1:0] CRED_ONE  = CW'(1);
    localparam logic [CW-1:0] CRED_ZERO = CW'(0);

    state_e               state_q, state_d;
    logic                 vc_q, vc_d;
    logic [1:0]           dst_x_q, dst_x_d;
    logic [1:0]           dst_y_q, dst_y_d;
    logic [1:0][CW-1:0]   cred_q, cred_d;
    logic [34:0]          odata_q, odata_d;
    logic                 ovalid_q, ovalid_d;
    logic                 ovch_q, ovch_d;
    logic                 cred_err_q, cred_err_d;
    logic [15:0]          pkt_cnt_q, pkt_cnt_d;

    logic                 avail_s;
    logic                 s_ready_s;
    logic                 send_head_s;
    logic                 send_data_s;
    logic [1:0]           send_vc_s;
    logic [1:0]           ovf_s;

    function automatic logic [34:0] build_head(input logic [1:0] my_x, input logic [1:0] my_y,
                                               input logic [1:0] dx, input logic [1:0] dy);
        return {2'b01, 1'b0, 24'h000000, my_x, my_y, dx, dy};
    endfunction

    function automatic logic [34:0] build_data(input logic [31:0] data, input logic last);
        return {(last ? 2'b10 : 2'b00), 1'b0, data};
    endfunction

    // A flit may go out on the packet VC only with a credit left and the router ready.
    always_comb begin
        avail_s = (cred_q[vc_q] != CRED_ZERO) && IRDY[vc_q];
    end

    // FSM state register.
    always_ff @(posedge clk or negedge RST_) begin
        if (!RST_) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (s_valid) begin
                    state_d = ST_HEAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HEAD: begin
                if (send_head_s) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_HEAD;
                end
            end
            ST_DATA: begin
                if (send_data_s && s_last) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DATA;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs; the lock only gates the head, a granted packet runs to its tail.
    always_comb begin
        s_ready_s   = 1'b0;
        send_head_s = 1'b0;
        send_data_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                s_ready_s = 1'b0;
            end
            ST_HEAD: begin
                send_head_s = avail_s && !ILCK[vc_q];
            end
            ST_DATA: begin
                s_ready_s   = avail_s;
                send_data_s = s_valid && avail_s;
            end
            default: begin
                s_ready_s = 1'b0;
            end
        endcase
    end

    assign s_ready = s_ready_s;

    // Packet context is captured while the first beat waits in IDLE.
    always_comb begin
        if ((state_q == ST_IDLE) && s_valid) begin
            vc_d    = s_vc;
            dst_x_d = s_dst_x;
            dst_y_d = s_dst_y;
        end else begin
            vc_d    = vc_q;
            dst_x_d = dst_x_q;
            dst_y_d = dst_y_q;
        end
    end

    // Per-VC credit counters; a send and an ack in the same cycle cancel out.
    always_comb begin
        cred_d = cred_q;
        ovf_s  = 2'b00;
        for (int v = 0; v < 2; v++) begin
            send_vc_s[v] = (send_head_s || send_data_s) && (vc_q == 1'(v));
            if (send_vc_s[v] && !IACK[v]) begin
                cred_d[v] = cred_q[v] - CRED_ONE;
            end else if (!send_vc_s[v] && IACK[v]) begin
                if (cred_q[v] == CRED_MAX) begin
                    ovf_s[v] = 1'b1;
                end else begin
                    cred_d[v] = cred_q[v] + CRED_ONE;
                end
            end else begin
                cred_d[v] = cred_q[v];
            end
        end
        cred_err_d = cred_err_q || (ovf_s != 2'b00);
    end

    // Flit output path; data and VC hold their last value between flits.
    always_comb begin
        odata_d   = odata_q;
        ovch_d    = ovch_q;
        ovalid_d  = 1'b0;
        pkt_cnt_d = pkt_cnt_q;
        if (send_head_s) begin
            odata_d  = build_head(MY_XPOS, MY_YPOS, dst_x_q, dst_y_q);
            ovch_d   = vc_q;
            ovalid_d = 1'b1;
        end else if (send_data_s) begin
            odata_d  = build_data(s_data, s_last);
            ovch_d   = vc_q;
            ovalid_d = 1'b1;
            if (s_last) begin
                pkt_cnt_d = pkt_cnt_q + 16'd1;
            end else begin
                pkt_cnt_d = pkt_cnt_q;
            end
        end else begin
            ovalid_d = 1'b0;
        end
    end

    // Datapath and status registers.
    always_ff @(posedge clk or negedge RST_) begin
        if (!RST_) begin
            vc_q       <= 1'b0;
            dst_x_q    <= 2'b00;
            dst_y_q    <= 2'b00;
            cred_q     <= {2{CRED_MAX}};
            odata_q    <= 35'h0;
            ovalid_q   <= 1'b0;
            ovch_q     <= 1'b0;
            cred_err_q <= 1'b0;
            pkt_cnt_q  <= 16'h0000;
        end else begin
            vc_q       <= vc_d;
            dst_x_q    <= dst_x_d;
            dst_y_q    <= dst_y_d;
            cred_q     <= cred_d;
            odata_q    <= odata_d;
            ovalid_q   <= ovalid_d;
            ovch_q     <= ovch_d;
            cred_err_q <= cred_err_d;
            pkt_cnt_q  <= pkt_cnt_d;
        end
    end

    assign ODATA    = odata_q;
    assign OVALID   = ovalid_q;
    assign OVCH     = ovch_q;
    assign cred_err = cred_err_q;
    assign pkt_cnt  = pkt_cnt_q;

endmodule

// File: tb/tb_noc_flit_injector.sv
// Scoreboard bench for noc_flit_injector: expected flits are queued as beats are
// accepted and compared in order as OVALID flits appear.
module tb_noc_flit_injector;

    logic        clk;
    logic        RST_;
    logic [1:0]  MY_XPOS, MY_YPOS;
    logic        s_valid, s_ready, s_last, s_vc;
    logic [31:0] s_data;
    logic [1:0]  s_dst_x, s_dst_y;
    logic [34:0] ODATA;
    logic        OVALID, OVCH;
    logic [1:0]  IACK, IRDY, ILCK;
    logic        cred_err;
    logic [15:0] pkt_cnt;

    logic [35:0] exp_q[$];
    logic [35:0] last_exp;
    int          n_chk;
    int          n_bad;
    int          flit_cnt;
    int          base;
    int          d;
    bit          abort_r;

    noc_flit_injector #(.DEPTH(4), .CW(4)) dut (
        .clk(clk), .RST_(RST_), .MY_XPOS(MY_XPOS), .MY_YPOS(MY_YPOS),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .s_vc(s_vc), .s_dst_x(s_dst_x), .s_dst_y(s_dst_y),
        .ODATA(ODATA), .OVALID(OVALID), .OVCH(OVCH),
        .IACK(IACK), .IRDY(IRDY), .ILCK(ILCK),
        .cred_err(cred_err), .pkt_cnt(pkt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [35:0] head_flit(input logic vc, input logic [1:0] dx, input logic [1:0] dy);
        return {vc, 2'b01, 1'b0, 24'h000000, MY_XPOS, MY_YPOS, dx, dy};
    endfunction

    function automatic logic [35:0] data_flit(input logic vc, input logic [31:0] dat, input logic last);
        return {vc, (last ? 2'b10 : 2'b00), 1'b0, dat};
    endfunction

    // Scoreboard compare of every emitted flit.
    always @(negedge clk) begin
        logic [35:0] e;
        if (RST_ && OVALID) begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else e = 36'hF_FFFF_FFFF;
            check_eq("flit", {OVCH, ODATA}, e);
            last_exp = e;
            flit_cnt++;
        end
    end

    // Drives one packet; called at a negedge, returns at a negedge.
    task automatic send_pkt(input logic vc, input logic [1:0] dx, input logic [1:0] dy,
                            input int nb, input logic [31:0] dbase);
        logic [31:0] dat;
        bit ok;
        s_vc = vc; s_dst_x = dx; s_dst_y = dy;
        exp_q.push_back(head_flit(vc, dx, dy));
        for (int b = 0; b < nb && !abort_r; b++) begin
            dat = dbase + 32'(b);
            s_data = dat; s_last = (b == nb - 1); s_valid = 1'b1;
            ok = 1'b0;
            for (int t = 0; t < 300 && !ok && !abort_r; t++) begin
                #1;
                if (!abort_r && s_ready) begin
                    ok = 1'b1;
                    exp_q.push_back(data_flit(vc, dat, s_last));
                end
                @(negedge clk);
            end
            if (!ok && !abort_r) check_eq("beat_tmo", {35'h0, ok}, 36'h1);
        end
        if (!abort_r) s_valid = 1'b0;
    endtask

    task automatic wait_flits(input int target);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 300 && !hit; i++) begin
            @(posedge clk); #2;
            if (flit_cnt >= target) hit = 1'b1;
        end
        if (!hit) check_eq("wait_tmo", 36'(flit_cnt), 36'(target));
    endtask

    task automatic ack_cycles(input logic [1:0] m, input int n);
        @(negedge clk); IACK = m;
        repeat (n) @(negedge clk);
        IACK = 2'b00;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got=%0d want=%0d", n_chk, 0);
        $fatal(1);
    end

    initial begin
        n_chk = 0; n_bad = 0; flit_cnt = 0; abort_r = 1'b0; last_exp = 36'h0;
        RST_ = 1'b0; MY_XPOS = 2'd1; MY_YPOS = 2'd3;
        s_valid = 1'b0; s_data = 32'h0; s_last = 1'b0; s_vc = 1'b0;
        s_dst_x = 2'd0; s_dst_y = 2'd0; IACK = 2'b00; IRDY = 2'b11; ILCK = 2'b00;
        repeat (3) @(negedge clk); #1;
        check_eq("rst_odata", {1'b0, ODATA}, 36'h0);
        check_eq("rst_ovalid", {35'h0, OVALID}, 36'h0);
        check_eq("rst_ovch", {35'h0, OVCH}, 36'h0);
        check_eq("rst_ready", {35'h0, s_ready}, 36'h0);
        check_eq("rst_err", {35'h0, cred_err}, 36'h0);
        check_eq("rst_pkt", {20'h0, pkt_cnt}, 36'h0);
        @(negedge clk); RST_ = 1'b1;
        @(negedge clk);

        // Basic 3-beat packet on VC1 uses all four credits.
        base = flit_cnt;
        send_pkt(1'b1, 2'd2, 2'd1, 3, 32'h1111_0000);
        repeat (2) @(negedge clk); #2;
        check_eq("t1_cnt", 36'(flit_cnt - base), 36'd4);
        check_eq("t1_pkt", {20'h0, pkt_cnt}, 36'd1);
        check_eq("t1_hold", {OVCH, ODATA}, last_exp);
        check_eq("t1_idle", {35'h0, OVALID}, 36'h0);
        ack_cycles(2'b10, 4);
        @(negedge clk); #2;
        check_eq("t1_err", {35'h0, cred_err}, 36'h0);

        // Credit exhaustion and same-cycle send/ack on VC0.
        @(negedge clk);
        base = flit_cnt;
        fork
            send_pkt(1'b0, 2'd3, 2'd2, 6, 32'hA000_0000);
            begin
                wait_flits(base + 4);
                repeat (10) @(negedge clk); #2;
                check_eq("exh_cnt", 36'(flit_cnt - base), 36'd4);
                check_eq("exh_rdy", {35'h0, s_ready}, 36'h0);
                @(negedge clk); IACK = 2'b01;
                @(negedge clk); IACK = 2'b00;
                repeat (3) @(negedge clk); #2;
                check_eq("exh_one", 36'(flit_cnt - base), 36'd5);
                @(negedge clk); IACK = 2'b01;
                repeat (3) @(negedge clk); #2;
                check_eq("same_cyc", 36'(flit_cnt - base), 36'd7);
                repeat (3) @(negedge clk); IACK = 2'b00;
            end
        join
        repeat (2) @(negedge clk); #2;
        check_eq("t2_pkt", {20'h0, pkt_cnt}, 36'd2);
        check_eq("t2_err", {35'h0, cred_err}, 36'h0);

        // Lock holds the head only.
        @(negedge clk); ILCK = 2'b01;
        base = flit_cnt;
        fork
            send_pkt(1'b0, 2'd0, 2'd3, 3, 32'hB000_0010);
            begin
                repeat (10) @(negedge clk); #2;
                check_eq("lck_cnt", 36'(flit_cnt - base), 36'd0);
                check_eq("lck_ov", {35'h0, OVALID}, 36'h0);
                @(negedge clk); ILCK = 2'b00;
                @(negedge clk); #2;
                check_eq("lck_head", {35'h0, OVALID}, 36'h1);
                ILCK = 2'b01;
            end
        join
        repeat (2) @(negedge clk); #2;
        ILCK = 2'b00;
        check_eq("lck_all", 36'(flit_cnt - base), 36'd4);
        ack_cycles(2'b01, 4);

        // IRDY drop stalls the data phase, then an extra ack overflows.
        @(negedge clk);
        base = flit_cnt;
        fork
            send_pkt(1'b1, 2'd1, 2'd1, 3, 32'hC000_0020);
            begin
                wait_flits(base + 2);
                @(negedge clk); IRDY = 2'b01;
                #1;
                check_eq("irdy_rdy", {35'h0, s_ready}, 36'h0);
                d = flit_cnt - base;
                repeat (8) @(negedge clk); #2;
                check_eq("irdy_hold", 36'(flit_cnt - base), 36'(d));
                check_eq("irdy_ov", {35'h0, OVALID}, 36'h0);
                @(negedge clk); IRDY = 2'b11;
            end
        join
        repeat (2) @(negedge clk); #2;
        check_eq("irdy_all", 36'(flit_cnt - base), 36'd4);
        check_eq("t4_pkt", {20'h0, pkt_cnt}, 36'd4);
        ack_cycles(2'b10, 4);
        @(negedge clk); #2;
        check_eq("ovf_pre", {35'h0, cred_err}, 36'h0);
        ack_cycles(2'b10, 1);
        @(negedge clk); #2;
        check_eq("ovf_err", {35'h0, cred_err}, 36'h1);

        // Counter stayed at DEPTH: a 5-flit packet gets exactly 4 out, then reset mid-packet.
        @(negedge clk);
        base = flit_cnt;
        fork
            send_pkt(1'b1, 2'd2, 2'd2, 4, 32'hD000_0030);
            begin
                wait_flits(base + 4);
                repeat (6) @(negedge clk); #2;
                check_eq("cap_cnt", 36'(flit_cnt - base), 36'd4);
                @(negedge clk); RST_ = 1'b0; abort_r = 1'b1; s_valid = 1'b0;
                #1;
                check_eq("mr_ov", {35'h0, OVALID}, 36'h0);
                check_eq("mr_rdy", {35'h0, s_ready}, 36'h0);
                check_eq("mr_err", {35'h0, cred_err}, 36'h0);
                check_eq("mr_pkt", {20'h0, pkt_cnt}, 36'h0);
            end
        join
        exp_q.delete();
        repeat (2) @(negedge clk);
        RST_ = 1'b1; abort_r = 1'b0;
        @(negedge clk);
        base = flit_cnt;
        send_pkt(1'b1, 2'd3, 2'd0, 3, 32'hE000_0040);
        repeat (2) @(negedge clk); #2;
        check_eq("post_cnt", 36'(flit_cnt - base), 36'd4);
        check_eq("post_pkt", {20'h0, pkt_cnt}, 36'd1);
        check_eq("q_empty", 36'(exp_q.size()), 36'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
